// File: rtl/ab_seq_pkg.sv
// Shared types and helpers for the A/B sequence transmitter.
package ab_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  // Field order is {A,B}.
  typedef logic [1:0] sym_t;

  localparam sym_t SYM_IDLE = 2'b00;

  // Bits needed for a down-counter that holds 0..n-1 (at least one bit).
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ab_sym_timer.sv
// Loadable down-counter that saturates at zero; tc flags the terminal count.
module ab_sym_timer #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         tc
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign tc = (cnt_q == '0);

endmodule

// File: rtl/ab_seq_tx.sv
// Frame-to-serial A/B symbol transmitter: per-symbol hold, trailing idle gap,
// done pulse, synchronous abort.
module ab_seq_tx
  import ab_seq_pkg::*;
#(
  parameter int NSYM = 8,
  parameter int HOLD = 1,
  parameter int GAP  = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [2*NSYM-1:0]         in_frame,
  input  logic [$clog2(NSYM+1)-1:0] in_len,
  input  logic                      abort,
  output logic                      A,
  output logic                      B,
  output logic                      busy,
  output logic                      done
);

  localparam int LW     = $clog2(NSYM+1);
  localparam int HW     = cnt_w(HOLD);
  localparam int GW     = cnt_w(GAP);
  localparam int GAP_LD = (GAP > 0) ? GAP - 1 : 0;
  localparam state_t POST_SEND = (GAP > 0) ? ST_GAP : ST_IDLE;

  state_t            state_q, state_d;
  sym_t              ab_q, ab_d;
  logic              done_q, done_d;
  logic [LW-1:0]     len_q, len_d, cnt_q, cnt_d, cnt_nxt, len_c;
  logic [2*NSYM-1:0] shift_q, shift_d;
  logic              accept, adv, last, hold_tc, gap_tc, hold_load, gap_load;

  assign len_c     = (in_len > LW'(NSYM)) ? LW'(NSYM) : in_len;
  assign accept    = (state_q == ST_IDLE) && in_valid && !abort;
  assign adv       = (state_q == ST_SEND) && !abort && hold_tc;
  assign cnt_nxt   = cnt_q + LW'(1);
  assign last      = (cnt_nxt == len_q);
  assign hold_load = accept || (adv && !last);
  assign gap_load  = (accept && (len_c == '0)) || (adv && last);

  ab_sym_timer #(.W(HW)) u_hold (
    .clk      (clk),
    .reset    (reset),
    .load     (hold_load),
    .en       (state_q == ST_SEND),
    .load_val (HW'(HOLD - 1)),
    .tc       (hold_tc)
  );

  ab_sym_timer #(.W(GW)) u_gap (
    .clk      (clk),
    .reset    (reset),
    .load     (gap_load),
    .en       (state_q == ST_GAP),
    .load_val (GW'(GAP_LD)),
    .tc       (gap_tc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ab_q    <= SYM_IDLE;
      done_q  <= 1'b0;
      len_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ab_q    <= ab_d;
      done_q  <= done_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
    end
  end

  // Frame payload only; its contents are meaningless outside SEND.
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) state_d = (len_c == '0) ? POST_SEND : ST_SEND;
      end
      ST_SEND: begin
        if (abort)             state_d = ST_IDLE;
        else if (hold_tc && last) state_d = POST_SEND;
      end
      ST_GAP: begin
        if (abort || gap_tc) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ab_d    = SYM_IDLE;
    done_d  = 1'b0;
    len_d   = len_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    if (accept) begin
      len_d   = len_c;
      cnt_d   = '0;
      shift_d = in_frame >> 2;
      if (len_c != '0) ab_d = in_frame[1:0];
      else             done_d = (GAP == 0);
    end else if ((state_q == ST_SEND) && !abort) begin
      if (!hold_tc) begin
        ab_d = ab_q;
      end else if (!last) begin
        ab_d    = shift_q[1:0];
        shift_d = shift_q >> 2;
        cnt_d   = cnt_nxt;
      end else begin
        done_d = (GAP == 0);
      end
    end else if ((state_q == ST_GAP) && !abort && gap_tc) begin
      done_d = 1'b1;
    end
  end

  assign in_ready = (state_q == ST_IDLE);
  assign busy     = (state_q != ST_IDLE);
  assign A        = ab_q[1];
  assign B        = ab_q[0];
  assign done     = done_q;

endmodule
